// File: rtl/sr_mul_iter_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package sr_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   localparam int unsigned MUL_W_DEF = 32;

endpackage

// File: rtl/sr_mul_iter_if.sv
// Core-to-multiplier bus: operands and launch request in, result and status out.
interface sr_mul_iter_if
   import sr_mul_pkg::*;
#(
   parameter int unsigned W = MUL_W_DEF
);
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         start;
   logic [W-1:0] res_mul;
   logic         end_mul;
   logic         busy;

   modport master (
      output a, b, start,
      input  res_mul, end_mul, busy
   );

   modport slave (
      input  a, b, start,
      output res_mul, end_mul, busy
   );
endinterface

// File: rtl/sr_mul_iter.sv
// Iterative shift-add multiplier for the schoolRISCV ALU_MUL operation.
// Retires BPC multiplier bits per cycle and returns the low W bits of a*b.
module sr_mul_iter
   import sr_mul_pkg::*;
#(
   parameter int unsigned W   = MUL_W_DEF,
   parameter int unsigned BPC = 1
) (
   input  logic        clk,
   input  logic        rst,
   sr_mul_iter_if.slave bus
);

   localparam int unsigned N  = W / BPC;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   mul_state_e    state_r;
   mul_state_e    stateNext_s;
   logic [W-1:0]  mcand_r;
   logic [W-1:0]  mcandNext_s;
   logic [W-1:0]  mplier_r;
   logic [W-1:0]  mplierNext_s;
   logic [W-1:0]  acc_r;
   logic [W-1:0]  accNext_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cntNext_s;
   logic [W-1:0]  res_r;
   logic [W-1:0]  resNext_s;

   // Running sum: ppSum_s[BPC] is acc plus this cycle's BPC partial products.
   logic [W-1:0]  ppSum_s [BPC+1];

   assign ppSum_s[0] = acc_r;

   for (genvar i = 0; i < BPC; i++) begin : g_pp
      assign ppSum_s[i+1] = ppSum_s[i] + (mplier_r[i] ? (mcand_r << i) : {W{1'b0}});
   end

   // Next-state and datapath update for IDLE/RUN/DONE.
   always_comb begin
      stateNext_s  = state_r;
      mcandNext_s  = mcand_r;
      mplierNext_s = mplier_r;
      accNext_s    = acc_r;
      cntNext_s    = cnt_r;
      resNext_s    = res_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               mcandNext_s  = bus.a;
               mplierNext_s = bus.b;
               accNext_s    = {W{1'b0}};
               cntNext_s    = CW'(N - 1);
               stateNext_s  = RUN;
            end else begin
               stateNext_s  = IDLE;
            end
         end
         RUN: begin
            if (!bus.start) begin
               // Flush of the MUL instruction: drop the operation, keep the old result.
               stateNext_s = IDLE;
            end else begin
               accNext_s    = ppSum_s[BPC];
               mcandNext_s  = mcand_r << BPC;
               mplierNext_s = mplier_r >> BPC;
               if (cnt_r == {CW{1'b0}}) begin
                  resNext_s   = ppSum_s[BPC];
                  stateNext_s = DONE;
               end else begin
                  cntNext_s   = cnt_r - CW'(1);
               end
            end
         end
         // Always return to IDLE so the finishing instruction's start cannot relaunch.
         DONE:    stateNext_s = IDLE;
         default: stateNext_s = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         mcand_r  <= {W{1'b0}};
         mplier_r <= {W{1'b0}};
         acc_r    <= {W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         res_r    <= {W{1'b0}};
      end else begin
         state_r  <= stateNext_s;
         mcand_r  <= mcandNext_s;
         mplier_r <= mplierNext_s;
         acc_r    <= accNext_s;
         cnt_r    <= cntNext_s;
         res_r    <= resNext_s;
      end
   end

   assign bus.res_mul = res_r;
   assign bus.end_mul = (state_r == DONE);
   assign bus.busy    = (state_r != IDLE);

endmodule

// File: tb/tb_sr_mul_iter.sv
// Self-checking bench for sr_mul_iter: BPC=1 and BPC=4 instances against a
// timing-level model (launch cycle + N + 1) with hand-computed spot checks.
module tb_sr_mul_iter;

   logic clk = 1'b0;
   logic rst1;
   logic rst4;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   cmpOn    = 1'b0;

   always #5 clk = ~clk;

   sr_mul_iter_if #(.W(32)) ifc1 ();
   sr_mul_iter_if #(.W(32)) ifc4 ();

   sr_mul_iter #(.W(32), .BPC(1)) dut1 (.clk(clk), .rst(rst1), .bus(ifc1));
   sr_mul_iter #(.W(32), .BPC(4)) dut4 (.clk(clk), .rst(rst4), .bus(ifc4));

   // Model: per instance, the cycle an operation launched, its product, the
   // cycle end_mul is due, and the result the output register must hold.
   int          nIt    [2] = '{32, 8};
   int          mLaunch[2] = '{-1, -1};
   int          mDone  [2] = '{-1, -1};
   logic [31:0] mProd  [2];
   logic [31:0] mRes   [2] = '{32'h0, 32'h0};

   function automatic logic [31:0] inA(input int d);
      return (d == 0) ? ifc1.a : ifc4.a;
   endfunction
   function automatic logic [31:0] inB(input int d);
      return (d == 0) ? ifc1.b : ifc4.b;
   endfunction
   function automatic logic inStart(input int d);
      return (d == 0) ? ifc1.start : ifc4.start;
   endfunction
   function automatic logic inRst(input int d);
      return (d == 0) ? rst1 : rst4;
   endfunction
   function automatic logic [31:0] outRes(input int d);
      return (d == 0) ? ifc1.res_mul : ifc4.res_mul;
   endfunction
   function automatic logic outEnd(input int d);
      return (d == 0) ? ifc1.end_mul : ifc4.end_mul;
   endfunction
   function automatic logic outBusy(input int d);
      return (d == 0) ? ifc1.busy : ifc4.busy;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", nm, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (inRst(d)) begin
            mLaunch[d] = -1;
            mDone[d]   = -1;
            mRes[d]    = 32'h0;
         end else if (mLaunch[d] < 0) begin
            if (cyc != mDone[d] && inStart(d)) begin
               mLaunch[d] = cyc;
               mProd[d]   = inA(d) * inB(d);
            end
         end else if (!inStart(d)) begin
            mLaunch[d] = -1;
         end else if (cyc == mLaunch[d] + nIt[d]) begin
            mRes[d]    = mProd[d];
            mDone[d]   = cyc + 1;
            mLaunch[d] = -1;
         end
      end
      cyc   = cyc + 1;
      cmpOn = 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmpOn) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d end_mul", d), {31'h0, outEnd(d)},
                {31'h0, (cyc == mDone[d])});
            chk($sformatf("dut%0d busy", d), {31'h0, outBusy(d)},
                {31'h0, (mLaunch[d] >= 0) || (cyc == mDone[d])});
            chk($sformatf("dut%0d res_mul", d), outRes(d), mRes[d]);
         end
      end
   end

   task automatic setIn(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic st);
      if (d == 0) begin
         ifc1.a = av; ifc1.b = bv; ifc1.start = st;
      end else begin
         ifc4.a = av; ifc4.b = bv; ifc4.start = st;
      end
   endtask

   task automatic waitEnd(input int d, input int launch, input int expLat,
                          input logic [31:0] expRes, input string nm);
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (outEnd(d)) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s end_mul timeout got=none exp=latency %0d", nm, expLat);
      end else begin
         chk({nm, " latency"}, 32'(cyc - launch), 32'(expLat));
         chk({nm, " result"}, outRes(d), expRes);
      end
   endtask

   // Launch with start held, scramble operands during RUN, wait for completion.
   task automatic doMul(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input bit keep, input int expLat, input logic [31:0] expRes,
                        input string nm);
      int launch;
      setIn(d, av, bv, 1'b1);
      launch = cyc;
      @(posedge clk); #1;
      setIn(d, $urandom, $urandom, 1'b1);
      waitEnd(d, launch, expLat, expRes, nm);
      @(posedge clk); #1;
      if (!keep) setIn(d, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      int launch;
      logic [31:0] ra;
      logic [31:0] rb;
      rst1 = 1'b1;
      rst4 = 1'b1;
      setIn(0, 32'h0, 32'h0, 1'b0);
      setIn(1, 32'h0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst1 = 1'b0;
      rst4 = 1'b0;
      @(negedge clk);
      chk("reset res_mul", ifc1.res_mul, 32'h0);
      chk("reset end_mul", {31'h0, ifc1.end_mul}, 32'h0);
      chk("reset busy", {31'h0, ifc1.busy}, 32'h0);
      @(posedge clk); #1;

      doMul(0, 32'd3, 32'd5, 1'b1, 33, 32'd15, "basic 3x5");
      doMul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, 32'h00000001, "wrap ffff");
      doMul(0, 32'h80000000, 32'd2, 1'b1, 33, 32'h00000000, "wrap msb");
      doMul(0, 32'd7, 32'd6, 1'b1, 33, 32'd42, "b2b 7x6");
      doMul(0, 32'hFFFFFFFE, 32'd9, 1'b0, 33, 32'hFFFFFFEE, "b2b -2x9");
      repeat (3) @(posedge clk);
      #1;

      // Reset in RUN cycle 10, start kept high so a fresh launch follows.
      setIn(0, 32'd100, 32'd100, 1'b1);
      launch = cyc;
      repeat (10) @(posedge clk);
      #1;
      rst1 = 1'b1;
      setIn(0, 32'd11, 32'd13, 1'b1);
      @(posedge clk); #1;
      rst1 = 1'b0;
      @(negedge clk);
      chk("midrst res_mul", ifc1.res_mul, 32'h0);
      chk("midrst busy", {31'h0, ifc1.busy}, 32'h0);
      chk("midrst end_mul", {31'h0, ifc1.end_mul}, 32'h0);
      launch = cyc;
      waitEnd(0, launch, 33, 32'd143, "post-reset 11x13");
      @(posedge clk); #1;

      // Abort: start dropped in RUN cycle 5.
      setIn(0, 32'd9, 32'd9, 1'b1);
      launch = cyc;
      repeat (5) @(posedge clk);
      #1;
      setIn(0, 32'd9, 32'd9, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort busy", {31'h0, ifc1.busy}, 32'h0);
      chk("abort res_mul", ifc1.res_mul, 32'd143);
      repeat (40) @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         doMul(0, ra, rb, (i != 19), 33, ra * rb, "rand bpc1");
      end

      doMul(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 9, 32'h242D2080, "bpc4 vector");
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         doMul(1, ra, rb, (i != 999), 9, ra * rb, "rand bpc4");
      end
      repeat (5) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
